// File: rtl/fairy_sram_pkg.sv
// Shared types and constants for the fairy SRAM-style memory responder.
package fairy_sram_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_WAIT = 2'd1,
    ST_RESP = 2'd2
  } state_t;

  localparam logic [3:0] CEN_NONE  = 4'b1111;
  localparam int         BYTE_W    = 8;
  localparam int         NUM_LANES = 4;
  localparam int         WORD_W    = NUM_LANES * BYTE_W;

endpackage

// File: rtl/fairy_sram_if.sv
// Request/response bundle of the fairy CPU SRAM-style port.
interface fairy_sram_if;
  import fairy_sram_pkg::*;

  logic [NUM_LANES-1:0] sram_cen;
  logic                 sram_wr;
  logic [31:0]          sram_addr;
  logic [WORD_W-1:0]    sram_wdata;
  logic                 sram_ack;
  logic                 sram_rrdy;
  logic [WORD_W-1:0]    sram_rdata;

  modport master (
    output sram_cen, sram_wr, sram_addr, sram_wdata,
    input  sram_ack, sram_rrdy, sram_rdata
  );

  modport slave (
    input  sram_cen, sram_wr, sram_addr, sram_wdata,
    output sram_ack, sram_rrdy, sram_rdata
  );

endinterface

// File: rtl/fairy_sram_bytemem.sv
// Single-port word array with per-byte write enables and a registered read.
module fairy_sram_bytemem
  import fairy_sram_pkg::*;
#(
  parameter int DEPTH_LOG2 = 10
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [DEPTH_LOG2-1:0] i_idx,
  input  logic                  i_we,
  input  logic [NUM_LANES-1:0]  i_wbe,
  input  logic [WORD_W-1:0]     i_wdata,
  input  logic                  i_re,
  output logic [WORD_W-1:0]     o_rdata
);

  logic [WORD_W-1:0] r_mem [2**DEPTH_LOG2];
  logic [WORD_W-1:0] r_q;

  always_ff @(posedge clk) begin
    if (i_we) begin
      for (int i = 0; i < NUM_LANES; i++) begin
        if (i_wbe[i]) begin
          r_mem[i_idx][i*BYTE_W +: BYTE_W] <= i_wdata[i*BYTE_W +: BYTE_W];
        end
      end
    end
  end

  // Read register only moves on a read, so it doubles as a response holding register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_q <= '0;
    end else if (i_re) begin
      r_q <= r_mem[i_idx];
    end
  end

  assign o_rdata = r_q;

endmodule

// File: rtl/fairy_sram_responder.sv
// Memory-side responder: accepts SRAM-style requests, acks them, returns reads after RD_LATENCY edges.
module fairy_sram_responder
  import fairy_sram_pkg::*;
#(
  parameter int DEPTH_LOG2 = 10,
  parameter int RD_LATENCY = 1
) (
  input  logic         aclk,
  input  logic         areset_n,
  fairy_sram_if.slave  sram,
  output logic         busy
);

  localparam logic [3:0] CNT_INIT = (RD_LATENCY > 1) ? 4'(RD_LATENCY - 2) : 4'd0;

  state_t                r_state;
  logic [3:0]            r_cnt;
  logic                  r_ack;
  logic                  r_rrdy;
  logic                  r_busy;
  logic [WORD_W-1:0]     r_rdata;

  logic                  w_req;
  logic                  w_accept;
  logic                  w_wr_accept;
  logic                  w_rd_accept;
  logic [DEPTH_LOG2-1:0] w_idx;
  logic [WORD_W-1:0]     w_mem_q;
  logic                  w_unused;

  assign w_req       = (sram.sram_cen != CEN_NONE);
  assign w_accept    = w_req && (r_state != ST_WAIT);
  assign w_wr_accept = w_accept && sram.sram_wr;
  assign w_rd_accept = w_accept && !sram.sram_wr;
  assign w_idx       = sram.sram_addr[DEPTH_LOG2+1:2];
  assign w_unused    = ^{sram.sram_addr[31:DEPTH_LOG2+2], sram.sram_addr[1:0]};

  fairy_sram_bytemem #(
    .DEPTH_LOG2 (DEPTH_LOG2)
  ) u_mem (
    .clk     (aclk),
    .rst_n   (areset_n),
    .i_idx   (w_idx),
    .i_we    (w_wr_accept),
    .i_wbe   (~sram.sram_cen),
    .i_wdata (sram.sram_wdata),
    .i_re    (w_rd_accept),
    .o_rdata (w_mem_q)
  );

  always_ff @(posedge aclk or negedge areset_n) begin
    if (!areset_n) begin
      r_state <= ST_IDLE;
      r_cnt   <= '0;
      r_ack   <= 1'b0;
      r_rrdy  <= 1'b0;
      r_busy  <= 1'b0;
      r_rdata <= '0;
    end else begin
      r_ack  <= 1'b0;
      r_rrdy <= 1'b0;
      case (r_state)
        ST_IDLE, ST_RESP: begin
          r_busy  <= 1'b0;
          r_state <= ST_IDLE;
          if (w_accept) begin
            r_ack <= 1'b1;
            if (!sram.sram_wr) begin
              if (RD_LATENCY == 1) begin
                r_state <= ST_RESP;
                r_rrdy  <= 1'b1;
              end else begin
                r_state <= ST_WAIT;
                r_cnt   <= CNT_INIT;
                r_busy  <= 1'b1;
              end
            end
          end
        end
        ST_WAIT: begin
          if (r_cnt == 4'd0) begin
            r_state <= ST_RESP;
            r_rrdy  <= 1'b1;
            r_busy  <= 1'b0;
            r_rdata <= w_mem_q;
          end else begin
            r_cnt <= r_cnt - 4'd1;
          end
        end
        default: begin
          r_state <= ST_IDLE;
          r_busy  <= 1'b0;
        end
      endcase
    end
  end

  // Single-edge latency has no room for a second register stage, so read straight from the array register.
  assign sram.sram_rdata = (RD_LATENCY == 1) ? w_mem_q : r_rdata;
  assign sram.sram_ack   = r_ack;
  assign sram.sram_rrdy  = r_rrdy;
  assign busy            = r_busy;

endmodule

// File: tb/tb_fairy_sram_responder.sv
// Directed self-checking bench for fairy_sram_responder at read latencies 1, 2, 3 and 4.
module tb_fairy_sram_responder;
  import fairy_sram_pkg::*;

  logic aclk;
  logic rstN;
  logic rst4N;
  logic busy1, busy2, busy3, busy4;
  int   nCompared;
  int   nMismatched;

  fairy_sram_if if1 ();
  fairy_sram_if if2 ();
  fairy_sram_if if3 ();
  fairy_sram_if if4 ();

  fairy_sram_responder #(.DEPTH_LOG2(10), .RD_LATENCY(1)) dut1 (
    .aclk(aclk), .areset_n(rstN), .sram(if1.slave), .busy(busy1));
  fairy_sram_responder #(.DEPTH_LOG2(10), .RD_LATENCY(2)) dut2 (
    .aclk(aclk), .areset_n(rstN), .sram(if2.slave), .busy(busy2));
  fairy_sram_responder #(.DEPTH_LOG2(10), .RD_LATENCY(3)) dut3 (
    .aclk(aclk), .areset_n(rstN), .sram(if3.slave), .busy(busy3));
  fairy_sram_responder #(.DEPTH_LOG2(10), .RD_LATENCY(4)) dut4 (
    .aclk(aclk), .areset_n(rst4N), .sram(if4.slave), .busy(busy4));

  initial aclk = 1'b0;
  always #5 aclk = ~aclk;

  task automatic tick();
    @(posedge aclk);
    #1;
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    nCompared++;
    if (obs !== exp) begin
      nMismatched++;
      $display("[TB] FAIL %s: got %08h, expected %08h", tag, obs, exp);
    end
  endtask

  task automatic applyStimulus(input int sel, input logic [3:0] cen, input logic wr,
                               input logic [31:0] addr, input logic [31:0] wdata);
    case (sel)
      1: begin if1.sram_cen = cen; if1.sram_wr = wr; if1.sram_addr = addr; if1.sram_wdata = wdata; end
      2: begin if2.sram_cen = cen; if2.sram_wr = wr; if2.sram_addr = addr; if2.sram_wdata = wdata; end
      3: begin if3.sram_cen = cen; if3.sram_wr = wr; if3.sram_addr = addr; if3.sram_wdata = wdata; end
      default: begin if4.sram_cen = cen; if4.sram_wr = wr; if4.sram_addr = addr; if4.sram_wdata = wdata; end
    endcase
  endtask

  // Latency-2 read on port 2: ack one edge after accept, response on the next.
  task automatic readCheck2(input string tag, input logic [31:0] addr, input logic [31:0] exp);
    applyStimulus(2, 4'b0000, 1'b0, addr, 32'h0);
    tick();
    checkOutput({tag, "_ack"}, 32'(if2.sram_ack), 32'd1);
    applyStimulus(2, CEN_NONE, 1'b0, 32'h0, 32'h0);
    tick();
    checkOutput({tag, "_rrdy"}, 32'(if2.sram_rrdy), 32'd1);
    checkOutput({tag, "_rdata"}, if2.sram_rdata, exp);
  endtask

  initial begin
    nCompared   = 0;
    nMismatched = 0;
    rstN  = 1'b0;
    rst4N = 1'b0;
    for (int s = 1; s <= 4; s++) applyStimulus(s, CEN_NONE, 1'b0, 32'h0, 32'h0);
    tick();
    tick();
    checkOutput("rst_ack", 32'(if2.sram_ack), 32'd0);
    checkOutput("rst_rrdy", 32'(if2.sram_rrdy), 32'd0);
    checkOutput("rst_rdata", if2.sram_rdata, 32'h0);
    checkOutput("rst_busy", 32'(busy2), 32'd0);
    rstN  = 1'b1;
    rst4N = 1'b1;
    tick();

    // Latency 2: full write then read with data held afterwards
    applyStimulus(2, 4'b0000, 1'b1, 32'h100, 32'hDEADBEEF);
    tick();
    checkOutput("t1_wr_ack", 32'(if2.sram_ack), 32'd1);
    checkOutput("t1_wr_rrdy", 32'(if2.sram_rrdy), 32'd0);
    applyStimulus(2, 4'b0000, 1'b0, 32'h100, 32'h0);
    tick();
    checkOutput("t1_rd_ack", 32'(if2.sram_ack), 32'd1);
    checkOutput("t1_wait_busy", 32'(busy2), 32'd1);
    checkOutput("t1_wait_rrdy", 32'(if2.sram_rrdy), 32'd0);
    checkOutput("t1_wait_rdata", if2.sram_rdata, 32'h0);
    applyStimulus(2, CEN_NONE, 1'b0, 32'h0, 32'h0);
    tick();
    checkOutput("t1_rrdy", 32'(if2.sram_rrdy), 32'd1);
    checkOutput("t1_rdata", if2.sram_rdata, 32'hDEADBEEF);
    checkOutput("t1_resp_ack", 32'(if2.sram_ack), 32'd0);
    checkOutput("t1_resp_busy", 32'(busy2), 32'd0);
    tick();
    checkOutput("t1_rrdy_pulse", 32'(if2.sram_rrdy), 32'd0);
    checkOutput("t1_rdata_hold", if2.sram_rdata, 32'hDEADBEEF);

    // Partial write on the low two bytes, read back-to-back behind it
    applyStimulus(2, 4'b0000, 1'b1, 32'h8, 32'h11223344);
    tick();
    applyStimulus(2, 4'b1100, 1'b1, 32'h8, 32'hAABBCCDD);
    tick();
    checkOutput("t2_pwr_ack", 32'(if2.sram_ack), 32'd1);
    readCheck2("t2_partial", 32'h8, 32'h1122CCDD);

    // Four back-to-back writes, each acked in consecutive cycles
    for (int i = 0; i < 4; i++) begin
      applyStimulus(2, 4'b0000, 1'b1, 32'(4 * i), 32'hA0B0C000 + 32'(i));
      tick();
      checkOutput($sformatf("t3_ack%0d", i), 32'(if2.sram_ack), 32'd1);
      checkOutput($sformatf("t3_rrdy%0d", i), 32'(if2.sram_rrdy), 32'd0);
    end
    applyStimulus(2, CEN_NONE, 1'b1, 32'h0, 32'h0);
    tick();
    checkOutput("t3_idle_ack", 32'(if2.sram_ack), 32'd0);
    for (int i = 0; i < 4; i++) begin
      readCheck2($sformatf("t3_rb%0d", i), 32'(4 * i), 32'hA0B0C000 + 32'(i));
    end

    // Address wrap modulo 1024 words and ignored low address bits
    applyStimulus(2, 4'b0000, 1'b1, 32'h1000, 32'h5A5A5A5A);
    tick();
    readCheck2("t5_wrap", 32'h0, 32'h5A5A5A5A);
    readCheck2("t5_unaligned", 32'h3, 32'h5A5A5A5A);
    readCheck2("t5_neighbour", 32'h4, 32'hA0B0C001);

    // Latency 3: second read held during WAIT is only accepted at the RESP edge
    applyStimulus(3, 4'b0000, 1'b1, 32'h20, 32'hCAFEF00D);
    tick();
    applyStimulus(3, 4'b0000, 1'b1, 32'h24, 32'h0BADF00D);
    tick();
    applyStimulus(3, 4'b0000, 1'b0, 32'h20, 32'h0);
    tick();
    checkOutput("t4_ack1", 32'(if3.sram_ack), 32'd1);
    checkOutput("t4_busy_w0", 32'(busy3), 32'd1);
    applyStimulus(3, 4'b1010, 1'b0, 32'h24, 32'h0);
    tick();
    checkOutput("t4_noack_w1", 32'(if3.sram_ack), 32'd0);
    checkOutput("t4_busy_w1", 32'(busy3), 32'd1);
    checkOutput("t4_rrdy_w1", 32'(if3.sram_rrdy), 32'd0);
    tick();
    checkOutput("t4_noack_resp", 32'(if3.sram_ack), 32'd0);
    checkOutput("t4_rrdy1", 32'(if3.sram_rrdy), 32'd1);
    checkOutput("t4_rdata1", if3.sram_rdata, 32'hCAFEF00D);
    checkOutput("t4_busy_resp", 32'(busy3), 32'd0);
    tick();
    checkOutput("t4_ack2", 32'(if3.sram_ack), 32'd1);
    checkOutput("t4_rrdy_off", 32'(if3.sram_rrdy), 32'd0);
    checkOutput("t4_busy2", 32'(busy3), 32'd1);
    checkOutput("t4_hold1", if3.sram_rdata, 32'hCAFEF00D);
    applyStimulus(3, CEN_NONE, 1'b0, 32'h20, 32'h0);
    tick();
    checkOutput("t4_rrdy_e1", 32'(if3.sram_rrdy), 32'd0);
    checkOutput("t4_ack_e1", 32'(if3.sram_ack), 32'd0);
    tick();
    checkOutput("t4_rrdy2", 32'(if3.sram_rrdy), 32'd1);
    checkOutput("t4_rdata2", if3.sram_rdata, 32'h0BADF00D);
    tick();
    checkOutput("t4_idle_busy", 32'(busy3), 32'd0);
    checkOutput("t4_idle_rrdy", 32'(if3.sram_rrdy), 32'd0);

    // Latency 1: data and rrdy arrive together with ack, including read-after-write
    applyStimulus(1, 4'b0000, 1'b1, 32'h40, 32'h13579BDF);
    tick();
    checkOutput("l1_wr_ack", 32'(if1.sram_ack), 32'd1);
    checkOutput("l1_wr_rrdy", 32'(if1.sram_rrdy), 32'd0);
    applyStimulus(1, 4'b0000, 1'b0, 32'h40, 32'h0);
    tick();
    checkOutput("l1_rd_ack", 32'(if1.sram_ack), 32'd1);
    checkOutput("l1_rd_rrdy", 32'(if1.sram_rrdy), 32'd1);
    checkOutput("l1_rd_data", if1.sram_rdata, 32'h13579BDF);
    checkOutput("l1_busy", 32'(busy1), 32'd0);
    applyStimulus(1, CEN_NONE, 1'b0, 32'h0, 32'h0);
    tick();
    checkOutput("l1_rrdy_off", 32'(if1.sram_rrdy), 32'd0);
    checkOutput("l1_hold", if1.sram_rdata, 32'h13579BDF);

    // Latency 4: complete one read, then reset in the middle of a second
    applyStimulus(4, 4'b0000, 1'b1, 32'h30, 32'h77665544);
    tick();
    applyStimulus(4, 4'b0000, 1'b0, 32'h30, 32'h0);
    tick();
    applyStimulus(4, CEN_NONE, 1'b0, 32'h0, 32'h0);
    tick();
    tick();
    checkOutput("t6_pre_rrdy_early", 32'(if4.sram_rrdy), 32'd0);
    tick();
    checkOutput("t6_pre_rrdy", 32'(if4.sram_rrdy), 32'd1);
    checkOutput("t6_pre_rdata", if4.sram_rdata, 32'h77665544);
    applyStimulus(4, 4'b0000, 1'b0, 32'h30, 32'h0);
    tick();
    checkOutput("t6_acc_ack", 32'(if4.sram_ack), 32'd1);
    checkOutput("t6_acc_busy", 32'(busy4), 32'd1);
    applyStimulus(4, CEN_NONE, 1'b0, 32'h0, 32'h0);
    rst4N = 1'b0;
    #2;
    checkOutput("t6_rst_ack", 32'(if4.sram_ack), 32'd0);
    checkOutput("t6_rst_busy", 32'(busy4), 32'd0);
    checkOutput("t6_rst_rdata", if4.sram_rdata, 32'h0);
    checkOutput("t6_rst_rrdy", 32'(if4.sram_rrdy), 32'd0);
    tick();
    rst4N = 1'b1;
    for (int i = 0; i < 6; i++) begin
      tick();
      checkOutput($sformatf("t6_no_rrdy%0d", i), 32'(if4.sram_rrdy), 32'd0);
    end
    applyStimulus(4, 4'b0000, 1'b0, 32'h30, 32'h0);
    tick();
    applyStimulus(4, CEN_NONE, 1'b0, 32'h0, 32'h0);
    tick();
    tick();
    tick();
    checkOutput("t6_ret_rrdy", 32'(if4.sram_rrdy), 32'd1);
    checkOutput("t6_retained", if4.sram_rdata, 32'h77665544);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCompared, nMismatched);
    $finish;
  end

endmodule
